dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 127 ++++++++++++
 tb/tb_dmem_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter with a three-state access sequencer
// Optional round-robin arbitration: define DMEM_ARB_RR_EN (default build is fixed priority, port 0 first).
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic              wack0,
    output logic              wack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_dataIn,
    output logic              mem_readmode,
    output logic              mem_writemode,
    input  logic [DATA_W-1:0] mem_dataOut,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t state, state_nxt;
    logic   sel;
    logic   op_we;
    logic   pick;
    logic   start;

`ifdef DMEM_ARB_RR_EN
    logic   rr_ptr;

    // Pointer only matters under contention; a lone requester always wins.
    always_comb begin
        pick = (req0 && req1) ? rr_ptr : req1;
    end
`else
    always_comb begin
        pick = !req0;
    end
`endif

    assign start = (state == IDLE) && (req0 || req1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            sel         <= 1'b0;
            op_we       <= 1'b0;
            mem_address <= '0;
            mem_dataIn  <= '0;
            rdata0      <= '0;
            rdata1      <= '0;
`ifdef DMEM_ARB_RR_EN
            rr_ptr      <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (start) begin
                sel         <= pick;
                op_we       <= pick ? we1 : we0;
                mem_address <= pick ? addr1 : addr0;
                mem_dataIn  <= pick ? wdata1 : wdata0;
`ifdef DMEM_ARB_RR_EN
                rr_ptr      <= ~rr_ptr;
`endif
            end
            if (state == ACCESS && !op_we) begin
                if (sel) begin
                    rdata1 <= mem_dataOut;
                end else begin
                    rdata0 <= mem_dataOut;
                end
            end
        end
    end

    // Strobes exist only in ACCESS so every access gives the memory a fresh rising edge.
    always_comb begin
        state_nxt     = state;
        gnt0          = 1'b0;
        gnt1          = 1'b0;
        rvalid0       = 1'b0;
        rvalid1       = 1'b0;
        wack0         = 1'b0;
        wack1         = 1'b0;
        mem_readmode  = 1'b0;
        mem_writemode = 1'b0;
        busy          = (state != IDLE);
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                state_nxt     = DONE;
                gnt0          = !sel;
                gnt1          = sel;
                mem_readmode  = !op_we;
                mem_writemode = op_we;
            end
            DONE: begin
                state_nxt = IDLE;
                rvalid0   = !sel && !op_we;
                rvalid1   = sel && !op_we;
                wack0     = !sel && op_we;
                wack1     = sel && op_we;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed vector table plus corner-case sequences for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1, mem_dataOut;
    logic        gnt0, gnt1, rvalid0, rvalid1, wack0, wack1;
    logic [31:0] rdata0, rdata1, mem_address, mem_dataIn;
    logic        mem_readmode, mem_writemode, busy;

    int n_vec = 0;
    int n_err = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .wack0(wack0), .wack1(wack1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_address(mem_address), .mem_dataIn(mem_dataIn),
        .mem_readmode(mem_readmode), .mem_writemode(mem_writemode),
        .mem_dataOut(mem_dataOut), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r0, r1, w0, w1;
        logic [31:0] a0, a1, d0, d1, dout;
        logic [8:0]  ctl;
        logic [31:0] e_addr, e_din, e_rd0, e_rd1;
    } vec_t;

    vec_t v[17];

    function automatic vec_t mk(logic r0, logic r1, logic w0, logic w1,
                                logic [31:0] a0, logic [31:0] a1, logic [31:0] d0, logic [31:0] d1,
                                logic [31:0] dout, logic [8:0] ctl, logic [31:0] e_addr,
                                logic [31:0] e_din, logic [31:0] e_rd0, logic [31:0] e_rd1);
        vec_t t;
        t.r0 = r0; t.r1 = r1; t.w0 = w0; t.w1 = w1;
        t.a0 = a0; t.a1 = a1; t.d0 = d0; t.d1 = d1; t.dout = dout;
        t.ctl = ctl; t.e_addr = e_addr; t.e_din = e_din; t.e_rd0 = e_rd0; t.e_rd1 = e_rd1;
        return t;
    endfunction

    function automatic logic [8:0] ctl_now();
        return {gnt0, gnt1, rvalid0, rvalid1, wack0, wack1, mem_readmode, mem_writemode, busy};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; mem_dataOut = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        idle_inputs();
        tick();
        @(negedge clk);
        reset = 0;
    endtask

    int          grants[4];
    int          ng;
    int          st;
    logic        pr0, pr1;
    logic        prev_strobe;

    initial begin
        // ctl = {gnt0,gnt1,rvalid0,rvalid1,wack0,wack1,rd,wr,busy}
        v[0]  = mk(0,0,0,0, 32'h0,  32'h0,  32'h0,        32'h0,        32'h0,        9'b000000000, 32'h0,  32'h0,        32'h0,        32'h0);
        v[1]  = mk(1,0,1,0, 32'h10, 32'h0,  32'hDEADBEEF, 32'h0,        32'h0,        9'b100000011, 32'h10, 32'hDEADBEEF, 32'h0,        32'h0);
        v[2]  = mk(0,0,0,0, 32'h0,  32'h0,  32'h0,        32'h0,        32'h0,        9'b000010001, 32'h10, 32'hDEADBEEF, 32'h0,        32'h0);
        v[3]  = mk(0,0,0,0, 32'h0,  32'h0,  32'h0,        32'h0,        32'h0,        9'b000000000, 32'h10, 32'hDEADBEEF, 32'h0,        32'h0);
        v[4]  = mk(0,1,0,0, 32'h0,  32'h10, 32'h0,        32'h12345678, 32'h0,        9'b010000101, 32'h10, 32'h12345678, 32'h0,        32'h0);
        v[5]  = mk(0,0,0,0, 32'h0,  32'h0,  32'h0,        32'h0,        32'hDEADBEEF, 9'b000100001, 32'h10, 32'h12345678, 32'h0,        32'hDEADBEEF);
        v[6]  = mk(0,0,0,0, 32'h0,  32'h0,  32'h0,        32'h0,        32'h0,        9'b000000000, 32'h10, 32'h12345678, 32'h0,        32'hDEADBEEF);
        v[7]  = mk(1,0,0,0, 32'h20, 32'h0,  32'h0,        32'h0,        32'h0,        9'b100000101, 32'h20, 32'h0,        32'h0,        32'hDEADBEEF);
        v[8]  = mk(1,0,0,0, 32'h20, 32'h0,  32'h0,        32'h0,        32'hCAFEF00D, 9'b001000001, 32'h20, 32'h0,        32'hCAFEF00D, 32'hDEADBEEF);
        v[9]  = mk(1,0,0,0, 32'h20, 32'h0,  32'h0,        32'h0,        32'h0,        9'b000000000, 32'h20, 32'h0,        32'hCAFEF00D, 32'hDEADBEEF);
        v[10] = mk(1,0,1,0, 32'h30, 32'h0,  32'hA5A5A5A5, 32'h0,        32'h0,        9'b100000011, 32'h30, 32'hA5A5A5A5, 32'hCAFEF00D, 32'hDEADBEEF);
        v[11] = mk(0,0,0,0, 32'h0,  32'h0,  32'h0,        32'h0,        32'h0,        9'b000010001, 32'h30, 32'hA5A5A5A5, 32'hCAFEF00D, 32'hDEADBEEF);
        v[12] = mk(0,0,0,0, 32'h0,  32'h0,  32'h0,        32'h0,        32'h0,        9'b000000000, 32'h30, 32'hA5A5A5A5, 32'hCAFEF00D, 32'hDEADBEEF);
        v[13] = mk(1,0,1,0, 32'h40, 32'h0,  32'h11111111, 32'h0,        32'h0,        9'b100000011, 32'h40, 32'h11111111, 32'hCAFEF00D, 32'hDEADBEEF);
        v[14] = mk(0,1,0,1, 32'h0,  32'h50, 32'h0,        32'h22222222, 32'h0,        9'b000010001, 32'h40, 32'h11111111, 32'hCAFEF00D, 32'hDEADBEEF);
        v[15] = mk(0,1,0,1, 32'h0,  32'h50, 32'h0,        32'h22222222, 32'h0,        9'b000000000, 32'h40, 32'h11111111, 32'hCAFEF00D, 32'hDEADBEEF);
        v[16] = mk(0,0,0,0, 32'h0,  32'h0,  32'h0,        32'h0,        32'h0,        9'b000000000, 32'h40, 32'h11111111, 32'hCAFEF00D, 32'hDEADBEEF);

        reset = 1;
        idle_inputs();
        req0 = 1; req1 = 1; we0 = 1; addr0 = 32'hFF; wdata0 = 32'hFF;
        repeat (2) tick();
        check("reset_ctl", {55'b0, ctl_now()}, 64'h0);
        check("reset_bus", {mem_address, mem_dataIn}, 64'h0);
        check("reset_rdata", {rdata0, rdata1}, 64'h0);
        idle_inputs();
        reset = 0;

        for (int i = 0; i < 17; i++) begin
            req0 = v[i].r0; req1 = v[i].r1; we0 = v[i].w0; we1 = v[i].w1;
            addr0 = v[i].a0; addr1 = v[i].a1; wdata0 = v[i].d0; wdata1 = v[i].d1;
            mem_dataOut = v[i].dout;
            tick();
            check($sformatf("vec%0d_ctl", i), {55'b0, ctl_now()}, {55'b0, v[i].ctl});
            check($sformatf("vec%0d_bus", i), {mem_address, mem_dataIn}, {v[i].e_addr, v[i].e_din});
            check($sformatf("vec%0d_rdata", i), {rdata0, rdata1}, {v[i].e_rd0, v[i].e_rd1});
        end

        // Contention: both ports hold req until four grants are seen.
        do_reset();
        req0 = 1; req1 = 1;
        ng = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            tick();
            if (gnt0 && gnt1) check("dual_grant", 64'd1, 64'd0);
            if (gnt0) begin grants[ng] = 0; ng++; end
            else if (gnt1) begin grants[ng] = 1; ng++; end
        end
        check("contention_count", 64'(ng), 64'd4);
`ifdef DMEM_ARB_RR_EN
        check("contention_order", {32'b0, 8'(grants[0]), 8'(grants[1]), 8'(grants[2]), 8'(grants[3])}, 64'h00_00_01_00_01);
`else
        check("contention_order", {32'b0, 8'(grants[0]), 8'(grants[1]), 8'(grants[2]), 8'(grants[3])}, 64'h0);
`endif

        // Reset mid-ACCESS aborts the store, then a lone req1 wins.
        do_reset();
        req0 = 1; we0 = 1; addr0 = 32'h60; wdata0 = 32'h77;
        tick();
        check("abort_pre", {55'b0, ctl_now()}, {55'b0, 9'b100000011});
        #1 reset = 1;
        #1;
        check("abort_ctl", {55'b0, ctl_now()}, 64'h0);
        check("abort_bus", {mem_address, mem_dataIn}, 64'h0);
        req0 = 0; we0 = 0; req1 = 1; we1 = 0; addr1 = 32'h70;
        tick();
        check("abort_hold", {55'b0, ctl_now()}, 64'h0);
        @(negedge clk);
        reset = 0;
        tick();
        check("abort_lone_req1", {55'b0, ctl_now()}, {55'b0, 9'b010000101});
        req1 = 0;
        tick();
        check("abort_done", {55'b0, ctl_now()}, {55'b0, 9'b000100001});

        // Random traffic against an independent state model.
        do_reset();
        st = 0; ng = 0; prev_strobe = 0;
        for (int c = 0; c < 600 && ng < 100; c++) begin
            req0 = 1'($urandom_range(0, 1)); req1 = 1'($urandom_range(0, 1));
            we0 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
            addr0 = $urandom; addr1 = $urandom; wdata0 = $urandom; wdata1 = $urandom;
            mem_dataOut = $urandom;
            pr0 = req0; pr1 = req1;
            tick();
            case (st)
                0: st = (pr0 || pr1) ? 1 : 0;
                1: st = 2;
                default: st = 0;
            endcase
            if (st == 1) ng++;
            check("rand_busy_strobe",
                  {61'b0, busy, mem_readmode | mem_writemode, mem_readmode & mem_writemode},
                  {61'b0, st != 0, st == 1, 1'b0});
            if (prev_strobe && (mem_readmode | mem_writemode)) check("rand_strobe_len", 64'd2, 64'd1);
            prev_strobe = mem_readmode | mem_writemode;
        end
        check("rand_grants", 64'(ng), 64'd100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
